minisys_mem_stage_hs: RTL

//  Parametrised MEM pipeline stage with a request/acknowledge memory bus and a memory-mapped IO bus.

---
 rtl/minisys_mem_stage_hs_pkg.sv | 34 +++
 rtl/minisys_mem_stage_hs_if.sv | 35 +++
 rtl/minisys_mem_stage_hs_mem_lane_align.sv | 51 +++++
 rtl/minisys_mem_stage_hs.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/minisys_mem_stage_hs_pkg.sv
// Memory-op codes, op decode helpers and FSM state codes for the MEM stage.
// Pure declarations; no logic, no latency.
package minisys_mem_pkg;

   localparam logic [3:0] MEMOP_NONE = 4'd0;
   localparam logic [3:0] MEMOP_LB   = 4'd1;
   localparam logic [3:0] MEMOP_LBU  = 4'd2;
   localparam logic [3:0] MEMOP_LH   = 4'd3;
   localparam logic [3:0] MEMOP_LHU  = 4'd4;
   localparam logic [3:0] MEMOP_LW   = 4'd5;
   localparam logic [3:0] MEMOP_SB   = 4'd6;
   localparam logic [3:0] MEMOP_SH   = 4'd7;
   localparam logic [3:0] MEMOP_SW   = 4'd8;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} memSize_t;
   typedef enum logic {ST_IDLE, ST_WAIT} memState_t;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= MEMOP_LB) && (op <= MEMOP_LW);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= MEMOP_SB) && (op <= MEMOP_SW);
   endfunction

   function automatic memSize_t op_size(input logic [3:0] op);
      case (op)
         MEMOP_LB, MEMOP_LBU, MEMOP_SB: return SZ_BYTE;
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SZ_HALF;
         default:                       return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/minisys_mem_stage_hs_if.sv
// RAM and IO request/acknowledge buses between the MEM stage (master) and memories (slave).
// Wires only; ack may arrive combinationally in the request cycle, req holds until ack or abort.
interface minisys_mem_stage_hs_if #(
   parameter int RAM_AW = 14
);
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [RAM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   logic              io_req;
   logic              io_we;
   logic [3:0]        io_be;
   logic [15:0]       io_addr;
   logic [31:0]       io_wdata;
   logic              io_ack;
   logic [31:0]       io_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output io_req, io_we, io_be, io_addr, io_wdata,
      input  io_ack, io_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  io_req, io_we, io_be, io_addr, io_wdata,
      output io_ack, io_rdata
   );
endinterface

// File: rtl/minisys_mem_stage_hs_mem_lane_align.sv
// Store byte enables / lane replication and load lane extract / sign-zero extension.
// Purely combinational; no state, no backpressure.
module mem_lane_align
   import minisys_mem_pkg::*;
(
   input  logic [3:0]  memOp,
   input  logic [1:0]  addrLo,
   input  logic [31:0] storeData,
   input  logic [31:0] loadWord,
   output logic [3:0]  byteEn,
   output logic [31:0] laneData,
   output logic [31:0] loadData
);
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   always_comb begin
      byteEn   = 4'hF;
      laneData = storeData;
      case (op_size(memOp))
         SZ_BYTE: begin
            byteEn   = 4'b0001 << addrLo;
            laneData = {4{storeData[7:0]}};
         end
         SZ_HALF: begin
            byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
            laneData = {2{storeData[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      loadByte = loadWord[7:0];
      case (addrLo)
         2'd1:    loadByte = loadWord[15:8];
         2'd2:    loadByte = loadWord[23:16];
         2'd3:    loadByte = loadWord[31:24];
         default: ;
      endcase
      loadHalf = addrLo[1] ? loadWord[31:16] : loadWord[15:0];
      case (memOp)
         MEMOP_LB:  loadData = {{24{loadByte[7]}}, loadByte};
         MEMOP_LBU: loadData = {24'd0, loadByte};
         MEMOP_LH:  loadData = {{16{loadHalf[15]}}, loadHalf};
         MEMOP_LHU: loadData = {16'd0, loadHalf};
         MEMOP_LW:  loadData = loadWord;
         default:   loadData = 32'd0;
      endcase
   end
endmodule

// File: rtl/minisys_mem_stage_hs.sv
// MEM stage: drives RAM/IO request buses, aligns data, times out, registers MEM/WB. Option: MEM_MISALIGN_TRAP_EN.
// Latency 1 cycle plus wait states; stall_m holds upstream while an access waits for ack.
module minisys_mem_stage_hs
   import minisys_mem_pkg::*;
#(
   parameter int         RAM_AW   = 14,
   parameter logic [7:0] IO_PAGE  = 8'hFF,
   parameter int         SIDE_W   = 74,
   parameter int         WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              valid_m,
   input  logic [3:0]        mem_op_m,
   input  logic              regwrite_m,
   input  logic              mem2reg_m,
   input  logic [4:0]        write_reg_m,
   input  logic [31:0]       alu_out_m,
   input  logic [31:0]       write_data_m,
   input  logic [SIDE_W-1:0] side_m,
   output logic              stall_m,
   minisys_mem_stage_hs_if.master bus,
   output logic              valid_w,
   output logic              regwrite_w,
   output logic              mem2reg_w,
   output logic [4:0]        write_reg_w,
   output logic [31:0]       alu_out_w,
   output logic [31:0]       read_data_w,
   output logic [SIDE_W-1:0] side_w,
   output logic              bus_err_w,
   output logic              misalign_w
);
   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   memState_t   state, nextState;
   logic [CW-1:0] waitCnt;
   logic        isLoad, isStore, isMemOp, nonMemOp, isIo, misal;
   logic        access, timeout, req, ack, done, trap;
   logic [3:0]  byteEn;
   logic [31:0] laneData, loadData, rdata;

   assign isLoad   = is_load(mem_op_m);
   assign isStore  = is_store(mem_op_m);
   assign isMemOp  = valid_m & (isLoad | isStore);
   assign nonMemOp = valid_m & ~(isLoad | isStore);
   assign isIo     = (alu_out_m[31:24] == IO_PAGE);

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      case (op_size(mem_op_m))
         SZ_HALF: misal = alu_out_m[0];
         SZ_WORD: misal = |alu_out_m[1:0];
         default: misal = 1'b0;
      endcase
   end
`else
   assign misal = 1'b0;
`endif

   // Gated with clrn so the request falls the instant reset asserts.
   assign access  = isMemOp & ~misal & clrn;
   assign trap    = isMemOp & misal;
   assign timeout = (state == ST_WAIT) && (WAIT_MAX != 0) && (waitCnt == CW'(WAIT_MAX));
   assign req     = access & ~timeout;
   assign ack     = isIo ? bus.io_ack : bus.mem_ack;
   assign rdata   = isIo ? bus.io_rdata : bus.mem_rdata;
   assign done    = req & ack;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state   <= ST_IDLE;
         waitCnt <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= (state == ST_WAIT && nextState == ST_WAIT) ? waitCnt + 1'b1 : '0;
      end
   end

   always_comb begin
      nextState = state;
      stall_m   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req && !ack) begin
               stall_m   = 1'b1;
               nextState = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done || timeout || !access) nextState = ST_IDLE;
            else                            stall_m   = 1'b1;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   mem_lane_align uAlign (
      .memOp     (mem_op_m),
      .addrLo    (alu_out_m[1:0]),
      .storeData (write_data_m),
      .loadWord  (rdata),
      .byteEn    (byteEn),
      .laneData  (laneData),
      .loadData  (loadData)
   );

   assign bus.mem_req   = req & ~isIo;
   assign bus.mem_we    = req & ~isIo & isStore;
   assign bus.mem_be    = byteEn;
   assign bus.mem_addr  = alu_out_m[RAM_AW+1:2];
   assign bus.mem_wdata = laneData;
   assign bus.io_req    = req & isIo;
   assign bus.io_we     = req & isIo & isStore;
   assign bus.io_be     = byteEn;
   assign bus.io_addr   = alu_out_m[17:2];
   assign bus.io_wdata  = laneData;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         valid_w     <= 1'b0;
         regwrite_w  <= 1'b0;
         mem2reg_w   <= 1'b0;
         write_reg_w <= '0;
         alu_out_w   <= '0;
         read_data_w <= '0;
         side_w      <= '0;
         bus_err_w   <= 1'b0;
         misalign_w  <= 1'b0;
      end else begin
         valid_w    <= 1'b0;
         regwrite_w <= 1'b0;
         bus_err_w  <= 1'b0;
         misalign_w <= 1'b0;
         if (done || timeout || trap || nonMemOp) begin
            valid_w     <= 1'b1;
            regwrite_w  <= regwrite_m & (done | nonMemOp);
            mem2reg_w   <= mem2reg_m;
            write_reg_w <= write_reg_m;
            alu_out_w   <= alu_out_m;
            read_data_w <= (done && isLoad) ? loadData : 32'd0;
            side_w      <= side_m;
            bus_err_w   <= timeout;
            misalign_w  <= trap;
         end
      end
   end
endmodule
